// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-port memory between NumReq masters
// Optional MEM_ARB_LOCK_EN adds lock_i to hold the grant for atomic read-modify-write.
module mem_arbiter #(
    parameter int NumReq    = 2,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq-1:0]             we_i,
    input  logic [NumReq*AddrWidth-1:0]   addr_i,
    input  logic [NumReq*DataWidth-1:0]   wdata_i,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NumReq-1:0]             lock_i,
`endif
    output logic [NumReq-1:0]             gnt_o,
    output logic [NumReq-1:0]             rvalid_o,
    output logic [DataWidth-1:0]          rdata_o,
    output logic                          mem_we_o,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic [DataWidth-1:0]          mem_wdata_o,
    input  logic [DataWidth-1:0]          mem_rdata_i
);

    localparam int IdW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [IdW-1:0]       r_rr_ptr;
    logic                 r_resp_valid;
    logic [IdW-1:0]       r_resp_id;
    logic [DataWidth-1:0] r_rdata;

    int                   w_idx;
    logic [IdW-1:0]       w_cand;
    logic [IdW-1:0]       w_winner;
    logic                 w_found;
    logic                 w_any;
    logic                 w_lock;
    logic [IdW-1:0]       w_next_ptr;

    // First asserted request scanning upward from the pointer, wrapping at NumReq.
    always_comb begin
        w_idx    = 0;
        w_cand   = '0;
        w_found  = 1'b0;
        w_winner = '0;
        w_lock   = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (!w_found) begin
                w_idx  = (int'(r_rr_ptr) + i) % NumReq;
                w_cand = IdW'(w_idx);
                if (req_i[w_cand]) begin
                    w_found  = 1'b1;
                    w_winner = w_cand;
                end
            end
        end
`ifdef MEM_ARB_LOCK_EN
        w_lock = r_resp_valid & lock_i[r_resp_id] & req_i[r_resp_id];
        if (w_lock) begin
            w_found  = 1'b1;
            w_winner = r_resp_id;
        end
`endif
    end

    assign w_any      = w_found & ~rst_i;
    assign w_next_ptr = (w_winner == IdW'(NumReq - 1)) ? '0 : w_winner + IdW'(1);

    assign gnt_o       = w_any ? (NumReq'(1) << w_winner) : '0;
    assign mem_we_o    = w_any & we_i[w_winner];
    assign mem_addr_o  = addr_i[w_winner*AddrWidth +: AddrWidth];
    assign mem_wdata_o = wdata_i[w_winner*DataWidth +: DataWidth];

    assign rvalid_o = r_resp_valid ? (NumReq'(1) << r_resp_id) : '0;
    assign rdata_o  = r_rdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_rdata      <= '0;
        end else begin
            r_resp_valid <= w_any;
            if (w_any) begin
                r_resp_id <= w_winner;
                if (!w_lock) begin
                    r_rr_ptr <= w_next_ptr;
                end
                // Writes are acknowledged via rvalid but leave the read register untouched.
                if (!we_i[w_winner]) begin
                    r_rdata <= mem_rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;

    localparam int NumReq = 2;
    localparam int AW     = 32;
    localparam int DW     = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NumReq-1:0] req_i;
    logic [NumReq-1:0] we_i;
    logic [AW-1:0]     a0, a1;
    logic [DW-1:0]     d0, d1;
    logic [NumReq-1:0] lock_i;
    logic [NumReq-1:0] gnt_o;
    logic [NumReq-1:0] rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic              mem_we_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_wdata_o;
    logic [DW-1:0]     mem_rdata_i;

    logic [DW-1:0]     mem [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (mem_we_o) mem[mem_addr_o[7:2]] <= mem_wdata_o;
    end
    assign mem_rdata_i = mem[mem_addr_o[7:2]];

    mem_arbiter #(.NumReq(NumReq), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      ({a1, a0}),
        .wdata_i     ({d1, d0}),
`ifdef MEM_ARB_LOCK_EN
        .lock_i      (lock_i),
`endif
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    logic [1:0]  exp_g [4];
    logic [31:0] exp_d [4];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 32'hCAFEF00D;
        mem[4] = 32'hDEADBEEF;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_d = '{32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678};

        rst_i = 1'b1; req_i = 2'b11; we_i = 2'b11; lock_i = 2'b00;
        a0 = 32'h10; a1 = 32'h0; d0 = 32'h0; d1 = 32'h0;
        #1;
        check_eq("rst_gnt", 32'(gnt_o), 32'h0);
        check_eq("rst_mem_we", 32'(mem_we_o), 32'h0);
        repeat (2) tick();
        check_eq("rst_gnt_held", 32'(gnt_o), 32'h0);
        check_eq("rst_rvalid", 32'(rvalid_o), 32'h0);
        check_eq("rst_rdata", rdata_o, 32'h0);

        // release: both request, requester 0 wins first
        rst_i = 1'b0; we_i = 2'b00;
        #1;
        check_eq("rel_gnt", 32'(gnt_o), 32'h1);
        check_eq("rel_addr", mem_addr_o, 32'h10);
        check_eq("rel_mem_we", 32'(mem_we_o), 32'h0);
        tick();
        check_eq("rd0_rvalid", 32'(rvalid_o), 32'h1);
        check_eq("rd0_rdata", rdata_o, 32'hDEADBEEF);
        req_i = 2'b10;
        #1;
        check_eq("rd1_gnt", 32'(gnt_o), 32'h2);
        tick();
        check_eq("rd1_rvalid", 32'(rvalid_o), 32'h2);
        check_eq("rd1_rdata", rdata_o, 32'hCAFEF00D);

        // write from 0 then read same address from 1
        req_i = 2'b01; we_i = 2'b01; a0 = 32'h20; d0 = 32'h12345678;
        #1;
        check_eq("wr_gnt", 32'(gnt_o), 32'h1);
        check_eq("wr_mem_we", 32'(mem_we_o), 32'h1);
        check_eq("wr_wdata", mem_wdata_o, 32'h12345678);
        tick();
        check_eq("wr_ack", 32'(rvalid_o), 32'h1);
        check_eq("wr_rdata_hold", rdata_o, 32'hCAFEF00D);
        req_i = 2'b10; we_i = 2'b00; a1 = 32'h20;
        #1;
        check_eq("raw_gnt", 32'(gnt_o), 32'h2);
        check_eq("raw_mem_we", 32'(mem_we_o), 32'h0);
        tick();
        check_eq("raw_rvalid", 32'(rvalid_o), 32'h2);
        check_eq("raw_rdata", rdata_o, 32'h12345678);

        // contention: alternating grants
        req_i = 2'b11; a0 = 32'h10; a1 = 32'h20;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("cont_gnt%0d", k), 32'(gnt_o), 32'(exp_g[k]));
            tick();
            check_eq($sformatf("cont_rvalid%0d", k), 32'(rvalid_o), 32'(exp_g[k]));
            check_eq($sformatf("cont_rdata%0d", k), rdata_o, exp_d[k]);
        end
        req_i = 2'b00;
        #1;
        check_eq("idle_gnt", 32'(gnt_o), 32'h0);
        check_eq("idle_mem_we", 32'(mem_we_o), 32'h0);
        check_eq("idle_addr_req0", mem_addr_o, 32'h10);
        tick();
        check_eq("idle_rvalid", 32'(rvalid_o), 32'h0);
        check_eq("idle_rdata_hold", rdata_o, 32'h12345678);

        // single requester continuously granted
        req_i = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("solo_gnt%0d", k), 32'(gnt_o), 32'h2);
            tick();
        end

        // reset mid-operation
        req_i = 2'b01;
        #1;
        check_eq("mid_gnt0", 32'(gnt_o), 32'h1);
        tick();
        req_i = 2'b11;
        #1;
        check_eq("mid_gnt1", 32'(gnt_o), 32'h2);
        rst_i = 1'b1;
        #1;
        check_eq("mid_rst_gnt", 32'(gnt_o), 32'h0);
        check_eq("mid_rst_rvalid", 32'(rvalid_o), 32'h0);
        check_eq("mid_rst_rdata", rdata_o, 32'h0);
        rst_i = 1'b0; req_i = 2'b00;
        tick();
        check_eq("mid_no_rvalid", 32'(rvalid_o), 32'h0);
        req_i = 2'b11;
        #1;
        check_eq("mid_ptr0_gnt", 32'(gnt_o), 32'h1);
        tick();

`ifdef MEM_ARB_LOCK_EN
        req_i = 2'b01; lock_i = 2'b01;
        #1;
        check_eq("lock_gnt0", 32'(gnt_o), 32'h1);
        tick();
        req_i = 2'b11;
        for (int k = 1; k < 3; k++) begin
            #1;
            check_eq($sformatf("lock_gnt%0d", k), 32'(gnt_o), 32'h1);
            tick();
        end
        lock_i = 2'b00;
        #1;
        check_eq("unlock_gnt", 32'(gnt_o), 32'h2);
        tick();
`endif

        req_i = 2'b00;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
